// File: rtl/shift_reg_burst.sv
// shift_reg_burst: parametrised universal shift register with counted burst engine.
// Supports hold, shift left, shift right and parallel load, plus a BUSY/DONE
// burst mode that shifts CNT times in a latched direction.
// Optional registered parity output is enabled by defining SHIFT_REG_BURST_PARITY_EN;
// without it PAR is tied low and no parity logic exists.
module shift_reg_burst #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             SI_L,
    input  logic             SI_R,
    input  logic [WIDTH-1:0] PD,
    input  logic             START,
    input  logic [CNT_W-1:0] CNT,
    output logic [WIDTH-1:0] Q,
    output logic             SO_L,
    output logic             SO_R,
    output logic             BUSY,
    output logic             DONE,
    output logic             PAR
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_shl;
    logic [WIDTH-1:0] q_shr;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] rem_nxt;
    logic             dir;        // 0 = left, 1 = right
    logic             dir_nxt;
    logic             done_r;
    logic             done_nxt;
    logic             mode_shift;

    // Both shift candidates; serial inputs are taken live at the edge
    assign q_shl      = {q_r[WIDTH-2:0], SI_R};
    assign q_shr      = {SI_L, q_r[WIDTH-1:1]};
    assign mode_shift = (MODE == 2'b01) || (MODE == 2'b10);

    // State register: FSM state, shift data, burst count, direction and DONE pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            q_r    <= '0;
            rem    <= '0;
            dir    <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            q_r    <= q_nxt;
            rem    <= rem_nxt;
            dir    <= dir_nxt;
            done_r <= done_nxt;
        end
    end

    // Next-state logic; DONE defaults low so it clears after one cycle even with EN=0
    always_comb begin
        state_nxt = state;
        q_nxt     = q_r;
        rem_nxt   = rem;
        dir_nxt   = dir;
        done_nxt  = 1'b0;
        if (EN) begin
            unique case (state)
                IDLE: begin
                    if (START) begin
                        if (mode_shift && (CNT != '0)) begin
                            // First shift happens on the accepting edge itself
                            dir_nxt = MODE[1];
                            q_nxt   = MODE[1] ? q_shr : q_shl;
                            rem_nxt = CNT - CNT_ONE;
                            if (CNT == CNT_ONE) begin
                                done_nxt = 1'b1;
                            end else begin
                                state_nxt = BURST;
                            end
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end else begin
                        unique case (MODE)
                            2'b01:   q_nxt = q_shl;
                            2'b10:   q_nxt = q_shr;
                            2'b11:   q_nxt = PD;
                            default: q_nxt = q_r;
                        endcase
                    end
                end
                BURST: begin
                    q_nxt   = dir ? q_shr : q_shl;
                    rem_nxt = rem - CNT_ONE;
                    if (rem == CNT_ONE) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs derived from registered state only
    always_comb begin
        Q    = q_r;
        SO_L = q_r[WIDTH-1];
        SO_R = q_r[0];
        BUSY = (state == BURST);
        DONE = done_r;
    end

`ifdef SHIFT_REG_BURST_PARITY_EN
    logic par_r;

    // Parity tracks the value Q takes at this edge, so it is computed from q_nxt
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_r <= 1'b0;
        end else if (EN) begin
            par_r <= ^q_nxt;
        end
    end

    assign PAR = par_r;
`else
    assign PAR = 1'b0;
`endif

    a_busy_done_excl : assert property (@(posedge CLK) disable iff (RST) !(BUSY && DONE));
    a_burst_rem_nz   : assert property (@(posedge CLK) disable iff (RST) (state == BURST) |-> (rem != '0));

endmodule

// File: tb/tb_shift_reg_burst.sv
// Self-checking bench for shift_reg_burst at WIDTH=8 against a behavioural model.
module tb_shift_reg_burst;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          CLK;
    logic          RST;
    logic          EN;
    logic [1:0]    MODE;
    logic          SI_L;
    logic          SI_R;
    logic [W-1:0]  PD;
    logic          START;
    logic [CW-1:0] CNT;
    logic [W-1:0]  Q;
    logic          SO_L;
    logic          SO_R;
    logic          BUSY;
    logic          DONE;
    logic          PAR;

    int total = 0;
    int bad   = 0;

    // Model: register value, shifts still owed by a burst, direction, DONE pulse
    logic [W-1:0] m_q;
    int           m_left;
    logic         m_dir;
    logic         m_done;

    shift_reg_burst #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .SI_L(SI_L), .SI_R(SI_R),
        .PD(PD), .START(START), .CNT(CNT), .Q(Q), .SO_L(SO_L), .SO_R(SO_R),
        .BUSY(BUSY), .DONE(DONE), .PAR(PAR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [W-1:0] shifted(input logic [W-1:0] v, input logic right);
        int x;
        x = int'(v);
        if (right) x = (x / 2) + (SI_L ? 128 : 0);
        else       x = (x * 2 + (SI_R ? 1 : 0)) % 256;
        return W'(x);
    endfunction

    function automatic logic exp_par(input logic [W-1:0] v);
`ifdef SHIFT_REG_BURST_PARITY_EN
        int ones = 0;
        for (int i = 0; i < W; i++) ones += int'(v[i]);
        return (ones % 2) == 1;
`else
        return 1'b0 && v[0];
`endif
    endfunction

    function automatic void model_reset();
        m_q = '0; m_left = 0; m_dir = 1'b0; m_done = 1'b0;
    endfunction

    function automatic void model_edge();
        logic nd;
        nd = 1'b0;
        if (EN) begin
            if (m_left > 0) begin
                m_q = shifted(m_q, m_dir);
                m_left--;
                nd = (m_left == 0);
            end else if (START) begin
                if ((MODE == 2'b01 || MODE == 2'b10) && int'(CNT) > 0) begin
                    m_dir  = (MODE == 2'b10);
                    m_q    = shifted(m_q, m_dir);
                    m_left = int'(CNT) - 1;
                    nd     = (m_left == 0);
                end else begin
                    nd = 1'b1;
                end
            end else begin
                case (MODE)
                    2'b01:   m_q = shifted(m_q, 1'b0);
                    2'b10:   m_q = shifted(m_q, 1'b1);
                    2'b11:   m_q = PD;
                    default: ;
                endcase
            end
        end
        m_done = nd;
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic en, input logic [1:0] mode, input logic start,
                          input int cnt, input logic sil, input logic sir, input logic [W-1:0] pd);
        EN = en; MODE = mode; START = start; CNT = CW'(cnt); SI_L = sil; SI_R = sir; PD = pd;
    endtask

    task automatic load(input logic [W-1:0] v);
        set_in(1'b1, 2'b11, 1'b0, 0, 1'b0, 1'b0, v);
        tick();
        set_in(1'b1, 2'b00, 1'b0, 0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        set_in(1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b0, 8'h00);
        model_reset();
        #2;
        total++; if (Q !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            bad++; $display("FAIL reset_init: Q=%h BUSY=%b DONE=%b want 00/0/0", Q, BUSY, DONE);
        end
        tick();
        RST = 1'b0;
        load(8'hFF);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        total++; if (Q !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            bad++; $display("FAIL reset_async: Q=%h BUSY=%b DONE=%b want 00/0/0", Q, BUSY, DONE);
        end
        RST = 1'b0;
        load(8'hA5);
        total++; if (Q !== 8'hA5 || SO_L !== 1'b1 || SO_R !== 1'b1) begin
            bad++; $display("FAIL load_a5: Q=%h SO_L=%b SO_R=%b want a5/1/1", Q, SO_L, SO_R);
        end
    endtask

    task automatic test_single_step();
        set_in(1'b1, 2'b01, 1'b0, 0, 1'b0, 1'b1, 8'h00);
        tick();
        total++; if (Q !== 8'h4B) begin
            bad++; $display("FAIL shl_step: Q=%h want 4b", Q);
        end
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (Q !== 8'h4B) begin
                bad++; $display("FAIL en_hold %0d: Q=%h want 4b", i, Q);
            end
        end
        load(8'h96);
        set_in(1'b1, 2'b10, 1'b0, 0, 1'b1, 1'b0, 8'hFF);
        tick();
        total++; if (Q !== 8'hCB || DONE !== 1'b0) begin
            bad++; $display("FAIL shr_step: Q=%h DONE=%b want cb/0", Q, DONE);
        end
    endtask

    task automatic test_burst_right();
        logic [W-1:0] eq [3];
        logic         eb [3];
        logic         ed [3];
        eq = '{8'h52, 8'h29, 8'h14};
        eb = '{1'b1, 1'b1, 1'b0};
        ed = '{1'b0, 1'b0, 1'b1};
        load(8'hA5);
        set_in(1'b1, 2'b10, 1'b1, 3, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            START = 1'b0;
            total++; if (Q !== eq[i] || BUSY !== eb[i] || DONE !== ed[i]) begin
                bad++; $display("FAIL burst_r step %0d: Q=%h BUSY=%b DONE=%b want %h/%b/%b",
                                i, Q, BUSY, DONE, eq[i], eb[i], ed[i]);
            end
        end
        MODE = 2'b00;
        tick();
        total++; if (Q !== 8'h14 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            bad++; $display("FAIL burst_r idle: Q=%h BUSY=%b DONE=%b want 14/0/0", Q, BUSY, DONE);
        end
    endtask

    task automatic test_stall();
        int dones = 0;
        load(8'h01);
        set_in(1'b1, 2'b01, 1'b1, 2, 1'b0, 1'b0, 8'h00);
        tick();
        total++; if (Q !== 8'h02 || BUSY !== 1'b1 || DONE !== 1'b0) begin
            bad++; $display("FAIL stall_first: Q=%h BUSY=%b DONE=%b want 02/1/0", Q, BUSY, DONE);
        end
        set_in(1'b0, 2'b11, 1'b1, 7, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (Q !== 8'h02 || BUSY !== 1'b1 || DONE !== 1'b0) begin
                bad++; $display("FAIL stall_hold %0d: Q=%h BUSY=%b DONE=%b want 02/1/0", i, Q, BUSY, DONE);
            end
        end
        set_in(1'b1, 2'b00, 1'b0, 0, 1'b1, 1'b0, 8'hFF);
        tick();
        dones += int'(DONE);
        total++; if (Q !== 8'h04 || BUSY !== 1'b0 || DONE !== 1'b1) begin
            bad++; $display("FAIL stall_last: Q=%h BUSY=%b DONE=%b want 04/0/1", Q, BUSY, DONE);
        end
        tick();
        dones += int'(DONE);
        total++; if (Q !== 8'h04 || dones != 1) begin
            bad++; $display("FAIL stall_done_once: Q=%h dones=%0d want 04/1", Q, dones);
        end
    endtask

    task automatic test_cnt_zero();
        load(8'h3C);
        set_in(1'b1, 2'b01, 1'b1, 0, 1'b1, 1'b1, 8'h00);
        tick();
        START = 1'b0; MODE = 2'b00;
        total++; if (Q !== 8'h3C || BUSY !== 1'b0 || DONE !== 1'b1) begin
            bad++; $display("FAIL cnt_zero: Q=%h BUSY=%b DONE=%b want 3c/0/1", Q, BUSY, DONE);
        end
        set_in(1'b1, 2'b11, 1'b1, 4, 1'b1, 1'b1, 8'h77);
        tick();
        START = 1'b0; MODE = 2'b00;
        total++; if (Q !== 8'h3C || BUSY !== 1'b0 || DONE !== 1'b1) begin
            bad++; $display("FAIL start_load_mode: Q=%h BUSY=%b DONE=%b want 3c/0/1", Q, BUSY, DONE);
        end
        tick();
        total++; if (DONE !== 1'b0) begin
            bad++; $display("FAIL done_clear: DONE=%b want 0", DONE);
        end
    endtask

    task automatic test_reset_mid_burst();
        load(8'h81);
        set_in(1'b1, 2'b01, 1'b1, 5, 1'b0, 1'b1, 8'h00);
        tick();
        START = 1'b0;
        tick();
        tick();
        total++; if (Q !== 8'h0F || BUSY !== 1'b1) begin
            bad++; $display("FAIL pre_reset_burst: Q=%h BUSY=%b want 0f/1", Q, BUSY);
        end
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        total++; if (Q !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            bad++; $display("FAIL reset_mid_burst: Q=%h BUSY=%b DONE=%b want 00/0/0", Q, BUSY, DONE);
        end
        RST = 1'b0;
        MODE = 2'b00;
        tick();
        total++; if (Q !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle: Q=%h BUSY=%b DONE=%b want 00/0/0", Q, BUSY, DONE);
        end
        set_in(1'b1, 2'b10, 1'b1, 2, 1'b1, 1'b0, 8'h00);
        tick();
        START = 1'b0;
        total++; if (Q !== 8'h80 || BUSY !== 1'b1) begin
            bad++; $display("FAIL restart_first: Q=%h BUSY=%b want 80/1", Q, BUSY);
        end
        tick();
        total++; if (Q !== 8'hC0 || BUSY !== 1'b0 || DONE !== 1'b1) begin
            bad++; $display("FAIL restart_last: Q=%h BUSY=%b DONE=%b want c0/0/1", Q, BUSY, DONE);
        end
    endtask

    task automatic test_parity();
        load(8'hA5);
        set_in(1'b1, 2'b10, 1'b0, 0, 1'b0, 1'b0, 8'h00);
`ifdef SHIFT_REG_BURST_PARITY_EN
        total++; if (PAR !== 1'b0) begin
            bad++; $display("FAIL par_a5: PAR=%b want 0", PAR);
        end
        tick();
        total++; if (Q !== 8'h52 || PAR !== 1'b1) begin
            bad++; $display("FAIL par_52: Q=%h PAR=%b want 52/1", Q, PAR);
        end
`else
        total++; if (PAR !== 1'b0) begin
            bad++; $display("FAIL par_off_a5: PAR=%b want 0", PAR);
        end
        tick();
        total++; if (Q !== 8'h52 || PAR !== 1'b0) begin
            bad++; $display("FAIL par_off_52: Q=%h PAR=%b want 52/0", Q, PAR);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                   int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 8'($urandom));
            tick();
            total++; if (Q !== m_q || BUSY !== (m_left > 0) || DONE !== m_done) begin
                bad++; $display("FAIL rand_core %0d: Q=%h BUSY=%b DONE=%b want %h/%b/%b",
                                i, Q, BUSY, DONE, m_q, m_left > 0, m_done);
            end
            total++; if (SO_L !== m_q[W-1] || SO_R !== m_q[0] || PAR !== exp_par(m_q)) begin
                bad++; $display("FAIL rand_aux %0d: SO_L=%b SO_R=%b PAR=%b want %b/%b/%b",
                                i, SO_L, SO_R, PAR, m_q[W-1], m_q[0], exp_par(m_q));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_burst_right();
        test_stall();
        test_cnt_zero();
        test_reset_mid_burst();
        test_parity();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_reg_burst.md
Name: shift_reg_burst

Overview:
- Parametrised universal shift register. Successor to the fixed 32-bit serial-in left-shift register.
- Adds configurable width, bidirectional shift, parallel load, serial outputs at both ends, and a counted burst-shift engine with BUSY/DONE handshake.
- Used as a serializer/deserializer front end and as a timing-tutorial datapath with adjustable depth.

Parameters:
- WIDTH, 32, register width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1, width of burst count input (localparam-style; overriding is permitted).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- EN  in  1  clock enable. Gates every register update except reset.
- MODE  in  2  00 hold, 01 shift left, 10 shift right, 11 parallel load.
- SI_L  in  1  serial in at MSB end; used by right shifts.
- SI_R  in  1  serial in at LSB end; used by left shifts.
- PD  in  WIDTH  parallel load data.
- START  in  1  burst request, sampled when EN=1 in IDLE.
- CNT  in  CNT_W  number of shifts in the burst.
- Q  out  WIDTH  register contents.
- SO_L  out  1  Q[WIDTH-1].
- SO_R  out  1  Q[0].
- BUSY  out  1  high while in BURST.
- DONE  out  1  one-cycle completion pulse.
- PAR  out  1  parity; see Optional Feature.

Behaviour:
- Reset (RST=1, async): Q=0, state=IDLE, remaining count=0, latched dir=0, BUSY=0, DONE=0. Takes effect immediately; it overrides EN, START and any burst in progress.
- Register updates occur on the rising CLK edge with EN=1. EN=0 freezes Q, state and count. DONE still clears after one cycle regardless of EN.
- Single-step operation (IDLE, START=0), Q at the next edge:
  - MODE 00: Q unchanged.
  - MODE 01: Q = {Q[WIDTH-2:0], SI_R}.
  - MODE 10: Q = {SI_L, Q[WIDTH-1:1]}.
  - MODE 11: Q = PD.
- State IDLE, START=1, EN=1:
  - MODE 01/10 with CNT>0: latch direction and CNT, then perform the first shift at this same edge. Remaining count becomes CNT-1. If the remaining count is 0, emit DONE next cycle and stay IDLE; otherwise go to BURST with BUSY=1 from the next cycle.
  - MODE 00/11 or CNT=0: no shift and no load. DONE=1 in the next cycle; stay IDLE.
- State BURST:
  - Each EN=1 edge performs one shift in the latched direction. Serial input (SI_R for left, SI_L for right) is sampled live at that edge. Remaining count decrements.
  - The edge that performs the last shift sets BUSY=0 and DONE=1 for exactly one cycle, and returns to IDLE.
  - MODE, PD and START are ignored while BUSY=1. There is no queueing.
  - EN=0 stalls the burst; BUSY stays high.
- Total BUSY duration = (number of EN=1 edges needed for CNT shifts) - 1 cycles.
- CNT > WIDTH is legal. The register flushes fully and continues shifting serial input.
- DONE and BUSY are never high in the same cycle.
- SO_L and SO_R are combinational from Q.
- No X propagation from unused inputs. Q never depends on PD except on a load.

Optional Feature:
- Macro SHIFT_REG_BURST_PARITY_EN.
- Defined: PAR = XOR-reduction of Q, registered. PAR updates on the same edge as Q, so it corresponds to the new Q value (computed from next-state Q). PAR resets to 0.
- Undefined: PAR tied to 0 and no parity logic is synthesized. All other behaviour is identical.

Test Plan:
- WIDTH=8, RST pulse mid-cycle with no clock -> Q=0x00, BUSY=0, DONE=0 immediately. MODE=11, PD=0xA5, EN=1, one edge -> Q=0xA5, SO_L=1, SO_R=1.
- From Q=0xA5: MODE=01, SI_R=1, one edge -> Q=0x4B. Then EN=0 for 3 edges -> Q stays 0x4B.
- From Q=0xA5: START=1, MODE=10, CNT=3, SI_L=0, EN=1 held -> Q sequence 0x52, 0x29, 0x14. BUSY high for 2 cycles, then DONE high for 1 cycle, then IDLE.
- From Q=0x01: START, MODE=01, CNT=2, SI_R=0, with EN low for 2 cycles after the first shift -> Q=0x02, held for 2 cycles, then 0x04. BUSY spans the stall. DONE pulses once. A START asserted during the stall is ignored.
- START with CNT=0 from Q=0x3C -> Q stays 0x3C, BUSY never rises, DONE pulses next cycle. Separately, RST asserted mid-burst of CNT=5 -> Q=0, BUSY=0, no DONE; the next START works normally.
- With SHIFT_REG_BURST_PARITY_EN defined: load 0xA5 -> PAR=0; shift right with SI_L=0 -> Q=0x52, PAR=1. Undefined: PAR=0 throughout.
